shift_add_multiplier: RTL and testbench
=======================================

# shift_add_multiplier

Sequential unsigned shift-and-add multiplier, the multiplication counterpart of the team's restoring-divider block. It accepts two N-bit operands on a start pulse and runs an internal Moore FSM through one add step and one shift step per multiplier bit. It returns a 2N-bit product with a one-cycle done strobe. The FSM and datapath (A/Q/M registers, iteration counter) live in a single module, so the block drops into the same arithmetic-unit test harness as the divider.

## Interface
- N, 4, operand width in bits (N >= 2)
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- multiplicand  input  N  operand M, captured in LOAD
- multiplier  input  N  operand Q, captured in LOAD
- product  output  2N  registered result; holds last completed result
- done  output  1  high for exactly one cycle when product becomes valid
- busy  output  1  high while in LOAD, ADD or SHIFT

## Operation
- Internal registers:
  - A: N+1 bits (accumulator plus carry)
  - Q: N bits
  - M: N bits
  - count: clog2(N+1) bits
  - product: 2N bits
  - state: 3 bits
- States: IDLE, LOAD, ADD, SHIFT, DONE.
  - IDLE: outputs done=0, busy=0. Goes to LOAD if start=1, else stays.
  - LOAD: M<=multiplicand, Q<=multiplier, A<=0, count<=0. Goes to ADD.
  - ADD: if Q[0]=1, A <= {0,A[N-1:0]} + {0,M} (N+1-bit result, carry kept in A[N]); else A unchanged. Goes to SHIFT.
  - SHIFT: {A,Q} <= {A,Q} >> 1 with 0 shifted into A[N]; count<=count+1.
    - If count+1 == N: product <= shifted {A[N-1:0],Q} and go to DONE.
    - Otherwise go to ADD.
  - DONE: done=1, busy=0. Goes to IDLE unconditionally.
  - Unused encodings go to IDLE.
- Outputs: done and busy are Moore decodes of state only. product changes only on the final SHIFT edge and on reset.
- Arithmetic: unsigned only. The result never exceeds (2^N-1)^2, so it always fits in 2N bits and there is no overflow flag.
- start asserted outside IDLE (including DONE) is ignored.
- Operand inputs are captured only in LOAD; changes while busy have no effect.
- Reset (rst=0, any time, including mid-operation) immediately forces all of the following:
  - state=IDLE
  - A, Q, M, count = 0
  - product=0, done=0, busy=0
  - Operation resumes only from a new start after rst returns high.

## Timing
- Edge 0: start is sampled high in IDLE.
- Edge 1: LOAD executes.
- Edges 2..2N+1: N ADD/SHIFT pairs, with iteration i (i=1..N) on edges 2i and 2i+1.
- Edge 2N+1: product is written.
- Cycle after edge 2N+1: done=1. This is 2N+1 cycles after the sampling edge, i.e. 9 for N=4.
- busy is high from after edge 0 through edge 2N+1, i.e. 2N+1 cycles.
- Edge 2N+2: DONE goes to IDLE.
- If start is held high continuously, the next run is sampled at edge 2N+3, giving a minimum start-to-start period of 2N+3 cycles (11 for N=4).
- product remains stable from the done cycle until the final SHIFT of the next run.
- Reset release: the first rising edge with rst=1 may sample start.

## Test plan
- Basic (N=4): multiplicand=13, multiplier=11, start pulse for 1 cycle -> done high 9 cycles after the sampling edge, product=8'h8F (143), busy high exactly 9 cycles.
- Corner values:
  - 15×15 -> product=8'hE1; checks the ADD carry into A[N].
  - 0×9 -> product=8'h00.
  - 9×0 -> product=8'h00.
  - 1×15 -> product=8'h0F.
- Back-to-back: start held high, operands changed only in IDLE (7×6, then 5×3) -> done pulses 11 cycles apart, with products 42 then 15; each done is exactly one cycle wide.
- Input immunity: start pulsed and operands changed to 15/15 mid-run of 12×10 -> product=120, no extra run, busy never retriggered.
- Reset mid-operation: rst=0 during the 3rd ADD of 13×11 after a prior result of 42 -> product=0, busy=0, done=0 immediately. After release, a new 3×3 run gives product=9.
- Exhaustive sweep: all 256 operand pairs for N=4, each compared with a reference a*b; also run N=8 with 255×255 -> product=16'hFE01, done after 17 cycles.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
// Sequential unsigned shift-and-add multiplier. A start pulse in IDLE loads
// the operands; the FSM then alternates one ADD step and one SHIFT step per
// multiplier bit and writes the 2N-bit product on the final SHIFT.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-low reset
//   start        request, only honoured in IDLE
//   multiplicand operand M (N bits), captured in LOAD
//   multiplier   operand Q (N bits), captured in LOAD
//   product      registered 2N-bit result, holds the last completed result
//   done         one-cycle strobe in the cycle after product is written
//   busy         high while in LOAD, ADD or SHIFT
module shift_add_multiplier #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic [2*N-1:0] product,
    output logic           done,
    output logic           busy
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] N_CNT = CW'(N);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [N:0]      a_r;
    logic [N-1:0]    q_r;
    logic [N-1:0]    m_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_inc_s;
    logic [N:0]      add_s;
    logic [2*N:0]    shift_s;
    logic            last_s;
    logic [2*N-1:0]  product_r;
    logic            done_r;
    logic            busy_r;

    // Datapath helpers: the add keeps its carry in A[N]; the shift moves the
    // whole {A,Q} pair right with a zero entering A[N].
    always_comb begin
        count_inc_s = count_r + CW'(1);
        last_s      = (count_inc_s == N_CNT);
        add_s       = {1'b0, a_r[N-1:0]} + {1'b0, m_r};
        shift_s     = {1'b0, a_r, q_r[N-1:1]};
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD:  state_next_s = ADD;
            ADD:   state_next_s = SHIFT;
            SHIFT: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = ADD;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register plus done/busy, registered from the next-state decode so
    // they line up exactly with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            done_r  <= (state_next_s == DONE);
            busy_r  <= (state_next_s == LOAD) || (state_next_s == ADD) ||
                       (state_next_s == SHIFT);
        end
    end

    // A/Q/M/count datapath and product register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r       <= '0;
            q_r       <= '0;
            m_r       <= '0;
            count_r   <= '0;
            product_r <= '0;
        end else begin
            case (state_r)
                LOAD: begin
                    m_r     <= multiplicand;
                    q_r     <= multiplier;
                    a_r     <= '0;
                    count_r <= '0;
                end
                ADD: begin
                    if (q_r[0]) begin
                        a_r <= add_s;
                    end else begin
                        a_r <= a_r;
                    end
                end
                SHIFT: begin
                    a_r     <= shift_s[2*N:N];
                    q_r     <= shift_s[N-1:0];
                    count_r <= count_inc_s;
                    if (last_s) begin
                        product_r <= shift_s[2*N-1:0];
                    end else begin
                        product_r <= product_r;
                    end
                end
                default: begin
                    a_r <= a_r;
                end
            endcase
        end
    end

    assign product = product_r;
    assign done    = done_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Testbench for shift_add_multiplier: N=4 and N=8 instances, scoreboard of
// expected products pushed at start and popped on each done strobe.
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  mc = 4'd0;
    logic [3:0]  mp = 4'd0;
    logic [7:0]  product;
    logic        done;
    logic        busy;

    logic        start8 = 1'b0;
    logic [7:0]  mc8 = 8'd0;
    logic [7:0]  mp8 = 8'd0;
    logic [15:0] product8;
    logic        done8;
    logic        busy8;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp8_q[$];

    shift_add_multiplier #(.N(4)) dut (
        .clk(clk), .rst(rst), .start(start), .multiplicand(mc),
        .multiplier(mp), .product(product), .done(done), .busy(busy)
    );

    shift_add_multiplier #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .multiplicand(mc8),
        .multiplier(mp8), .product(product8), .done(done8), .busy(busy8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every done strobe must match the oldest outstanding result.
    always @(negedge clk) begin
        if (done) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("product", 32'(product), 32'(exp_q.pop_front()));
        end
        if (done8) begin
            check("sb8_nonempty", 32'(exp8_q.size() != 0), 32'd1);
            if (exp8_q.size() != 0) check("product8", 32'(product8), 32'(exp8_q.pop_front()));
        end
    end

    // Called #1 after the sampling edge; returns edges-to-done and busy cycles.
    // With inject set, pulses start and changes operands mid-run.
    task automatic wait_done(input bit inject, output int lat, output int bcnt);
        lat = 0;
        bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            if (inject && lat == 3) begin
                start = 1'b1; mc = 4'd15; mp = 4'd15;
            end else if (inject && lat == 4) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit timing);
        int lat, bcnt;
        @(negedge clk);
        mc = a; mp = b; start = 1'b1;
        exp_q.push_back(16'(a) * 16'(b));
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1'b0, lat, bcnt);
        if (timing) begin
            check("latency", 32'(lat), 32'd9);
            check("busy_cycles", 32'(bcnt), 32'd9);
        end
        @(posedge clk); #1;
        check("done_width", 32'(done), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int lat, bcnt, t1, t2;
        #1;
        check("rst_product", 32'(product), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_product8", 32'(product8), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Basic and corner values
        run_op(4'd13, 4'd11, 1'b1);
        run_op(4'd15, 4'd15, 1'b1);
        run_op(4'd0, 4'd9, 1'b1);
        run_op(4'd9, 4'd0, 1'b1);
        run_op(4'd1, 4'd15, 1'b1);

        // Back-to-back with start held high
        @(negedge clk);
        mc = 4'd7; mp = 4'd6; start = 1'b1;
        exp_q.push_back(16'd42);
        @(posedge clk); #1;
        wait_done(1'b0, lat, bcnt);
        t1 = cyc;
        @(posedge clk); #1;
        check("b2b_done_width1", 32'(done), 32'd0);
        mc = 4'd5; mp = 4'd3;
        exp_q.push_back(16'd15);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1'b0, lat, bcnt);
        t2 = cyc;
        check("b2b_period", 32'(t2 - t1), 32'd11);
        @(posedge clk); #1;
        check("b2b_done_width2", 32'(done), 32'd0);

        // Input immunity: start pulse and operand change mid-run
        @(negedge clk);
        mc = 4'd12; mp = 4'd10; start = 1'b1;
        exp_q.push_back(16'd120);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1'b1, lat, bcnt);
        check("imm_latency", 32'(lat), 32'd9);
        check("imm_busy_cycles", 32'(bcnt), 32'd9);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("imm_no_retrigger", 32'(busy), 32'd0);
        end

        // Reset mid-operation, after a prior result of 42
        run_op(4'd7, 4'd6, 1'b0);
        check("pre_rst_product", 32'(product), 32'd42);
        @(negedge clk);
        mc = 4'd13; mp = 4'd11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_product", 32'(product), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op(4'd3, 4'd3, 1'b1);

        // Exhaustive sweep for N=4
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(4'(a), 4'(b), 1'b0);
            end
        end

        // N=8, 255 x 255
        @(negedge clk);
        mc8 = 8'd255; mp8 = 8'd255; start8 = 1'b1;
        exp8_q.push_back(16'hFE01);
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency8", 32'(lat), 32'd17);
        @(posedge clk); #1;
        check("done8_width", 32'(done8), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        check("sb8_drain", 32'(exp8_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
